// File: rtl/reg_ts_pkg.sv
// reg_ts_pkg: shared track constants and decoded-entry type for the register track selector
package reg_ts_pkg;
  localparam int RA_W = 2;
  localparam logic TRACK_RR = 1'b1;
  localparam logic TRACK_RRW = 1'b0;
  typedef struct packed {
    logic [RA_W-1:0] r1;
    logic [RA_W-1:0] r2;
    logic [RA_W-1:0] rw;
    logic rwEn;
  } decEntry_t;
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-write counters with busy vector and sticky underflow error
module reg_scoreboard #(
  parameter int RA_W = 2,
  parameter int CNT_W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic [RA_W-1:0] incAddr,
  input  logic dec,
  input  logic [RA_W-1:0] decAddr,
  output logic [2**RA_W-1:0] busy,
  output logic err
);
  localparam int NREG = 2**RA_W;
  logic [CNT_W-1:0] pend [NREG];
  logic decHit;
  assign decHit = dec && pend[decAddr] != '0;
  always_comb begin
    busy = '0;
    for (int i = 0; i < NREG; i++) busy[i] = pend[i] != '0;
  end
  // An inc and a dec on the same register cancel, leaving the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) pend[i] <= '0;
      err <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++)
        pend[i] <= pend[i] + CNT_W'(inc && incAddr == RA_W'(i)) - CNT_W'(decHit && decAddr == RA_W'(i));
      err <= err || (dec && !decHit);
    end
  end
endmodule

// File: rtl/reg_track_sel_pipe.sv
// reg_track_sel_pipe: registered register-track decoder with scoreboard stalls.
// REG_TS_ZERO_REG_EN hardwires register 0 (never written, read or tracked).
module reg_track_sel_pipe import reg_ts_pkg::*; #(
  parameter int RA_W = 2,
  parameter int CNT_W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic track_select,
  input  logic [RA_W-1:0] r_alpha,
  input  logic [RA_W-1:0] r_beta,
  input  logic [RA_W-1:0] r_gamma,
  output logic out_valid,
  input  logic out_ready,
  output logic [RA_W-1:0] r1,
  output logic [RA_W-1:0] r2,
  output logic [RA_W-1:0] rw,
  output logic rw_en,
  input  logic wb_valid,
  input  logic [RA_W-1:0] wb_addr,
  output logic hazard,
  output logic err
);
  localparam int NREG = 2**RA_W;
  logic [RA_W-1:0] dR1, dR2, dRw;
  logic dRwEn, accept, decEn;
  logic [NREG-1:0] busy, busyEff;
  always_comb begin
    dR1 = track_select == TRACK_RR ? r_alpha : r_beta;
    dR2 = track_select == TRACK_RR ? r_beta : r_gamma;
    dRw = track_select == TRACK_RR ? '0 : r_alpha;
`ifdef REG_TS_ZERO_REG_EN
    dRwEn = track_select == TRACK_RRW && r_alpha != '0;
    decEn = wb_valid && wb_addr != '0;
    busyEff = {busy[NREG-1:1], 1'b0};
`else
    dRwEn = track_select == TRACK_RRW;
    decEn = wb_valid;
    busyEff = busy;
`endif
    hazard = in_valid && (busyEff[dR1] || busyEff[dR2] || (dRwEn && busyEff[dRw]));
    in_ready = !hazard && (!out_valid || out_ready);
    accept = in_valid && in_ready;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      r1 <= '0;
      r2 <= '0;
      rw <= '0;
      rw_en <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      r1 <= dR1;
      r2 <= dR2;
      rw <= dRw;
      rw_en <= dRwEn;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
  reg_scoreboard #(.RA_W(RA_W), .CNT_W(CNT_W)) uSb (
    .clk(clk),
    .rst(rst),
    .inc(accept && dRwEn),
    .incAddr(dRw),
    .dec(decEn),
    .decAddr(wb_addr),
    .busy(busy),
    .err(err)
  );
endmodule

// File: tb/tb_reg_track_sel_pipe.sv
// tb_reg_track_sel_pipe: table-driven cycle vectors with an output scoreboard queue
module tb_reg_track_sel_pipe;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, track_select, out_valid, out_ready, rw_en, wb_valid, hazard, err;
  logic [1:0] r_alpha, r_beta, r_gamma, r1, r2, rw, wb_addr;
  always #5 clk = ~clk;

  reg_track_sel_pipe #(.RA_W(2), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .track_select(track_select), .r_alpha(r_alpha), .r_beta(r_beta), .r_gamma(r_gamma),
    .out_valid(out_valid), .out_ready(out_ready), .r1(r1), .r2(r2), .rw(rw), .rw_en(rw_en),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .hazard(hazard), .err(err)
  );

  typedef struct packed {logic [1:0] r1, r2, rw; logic rwEn;} ent_t;
  typedef struct {
    logic iv, ts;
    logic [1:0] a, b, g;
    logic wbV;
    logic [1:0] wbA;
    logic oRdy, expHaz;
  } vec_t;

  ent_t q[$];
  logic mOutValid;
  int checks = 0, errors = 0;
  vec_t tbl[16];

  function automatic vec_t mk(int iv, int ts, int a, int b, int g, int wbV, int wbA, int oRdy, int expHaz);
    vec_t v;
    v.iv = 1'(iv); v.ts = 1'(ts); v.a = 2'(a); v.b = 2'(b); v.g = 2'(g);
    v.wbV = 1'(wbV); v.wbA = 2'(wbA); v.oRdy = 1'(oRdy); v.expHaz = 1'(expHaz);
    return v;
  endfunction

  function automatic ent_t decodeExp(logic ts, logic [1:0] a, logic [1:0] b, logic [1:0] g);
    ent_t e;
    if (ts) e = '{r1: a, r2: b, rw: 2'd0, rwEn: 1'b0};
    else begin
      e = '{r1: b, r2: g, rw: a, rwEn: 1'b1};
`ifdef REG_TS_ZERO_REG_EN
      if (a == 2'd0) e.rwEn = 1'b0;
`endif
    end
    return e;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(vec_t v);
    logic expReady, acc;
    in_valid = v.iv; track_select = v.ts; r_alpha = v.a; r_beta = v.b; r_gamma = v.g;
    wb_valid = v.wbV; wb_addr = v.wbA; out_ready = v.oRdy;
    @(negedge clk);
    expReady = !v.expHaz && (!mOutValid || v.oRdy);
    chk("hazard", 32'(hazard), 32'(v.expHaz));
    chk("in_ready", 32'(in_ready), 32'(expReady));
    chk("out_valid", 32'(out_valid), 32'(mOutValid));
    if (mOutValid) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL entry: no expected entry queued at %0t", $time);
      end else begin
        chk("entry", 32'({r1, r2, rw, rw_en}), 32'(q[0]));
        if (v.oRdy) void'(q.pop_front());
      end
    end
    acc = v.iv && expReady;
    if (acc) q.push_back(decodeExp(v.ts, v.a, v.b, v.g));
    mOutValid = acc || (mOutValid && !v.oRdy);
    @(posedge clk); #1;
  endtask

  task automatic idleInputs();
    in_valid = 0; track_select = 0; r_alpha = 0; r_beta = 0; r_gamma = 0;
    wb_valid = 0; wb_addr = 0; out_ready = 1;
  endtask

  initial begin
    idleInputs();
    rst = 1;
    q.delete(); mOutValid = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_rw_en", 32'(rw_en), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;

    tbl[0]  = mk(1, 0, 3, 1, 2, 0, 0, 1, 0);
    tbl[1]  = mk(1, 1, 3, 0, 0, 0, 0, 1, 1);
    tbl[2]  = mk(1, 1, 3, 0, 0, 1, 3, 1, 1);
    tbl[3]  = mk(1, 1, 3, 0, 0, 0, 0, 1, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[5]  = mk(1, 1, 1, 2, 0, 0, 0, 0, 0);
    tbl[6]  = mk(1, 1, 2, 1, 0, 0, 0, 0, 0);
    tbl[7]  = mk(1, 1, 2, 1, 0, 0, 0, 0, 0);
    tbl[8]  = mk(1, 1, 2, 1, 0, 0, 0, 1, 0);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[10] = mk(1, 0, 1, 0, 0, 0, 0, 1, 0);
    tbl[11] = mk(1, 0, 2, 3, 1, 0, 0, 1, 1);
    tbl[12] = mk(1, 0, 1, 2, 3, 0, 0, 1, 1);
    tbl[13] = mk(0, 0, 0, 0, 0, 1, 1, 1, 0);
    tbl[14] = mk(1, 0, 2, 3, 1, 0, 0, 1, 0);
    tbl[15] = mk(0, 0, 0, 0, 0, 1, 2, 1, 0);
    for (int i = 0; i < 16; i++) step(tbl[i]);
    chk("queue_drained", 32'(q.size()), 0);

    @(negedge clk);
    chk("err_before", 32'(err), 0);
    @(posedge clk); #1;
    step(mk(0, 0, 0, 0, 0, 1, 2, 1, 0));
    @(negedge clk);
    chk("err_set", 32'(err), 1);
    @(posedge clk); #1;
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
    @(negedge clk);
    chk("err_sticky", 32'(err), 1);
    @(posedge clk); #1;

    step(mk(1, 0, 3, 1, 2, 0, 0, 0, 0));
    step(mk(1, 1, 3, 0, 0, 0, 0, 0, 1));
    idleInputs();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    q.delete(); mOutValid = 0;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_err", 32'(err), 0);
    chk("midrst_rw_en", 32'(rw_en), 0);
    @(posedge clk); #1;
    step(mk(1, 1, 3, 0, 0, 0, 0, 1, 0));
    step(mk(1, 0, 3, 3, 3, 0, 0, 1, 0));
    step(mk(0, 0, 0, 0, 0, 1, 3, 1, 0));

`ifdef REG_TS_ZERO_REG_EN
    step(mk(1, 0, 0, 1, 2, 0, 0, 1, 0));
    step(mk(1, 0, 0, 0, 0, 1, 0, 1, 0));
    step(mk(1, 1, 0, 0, 0, 1, 0, 1, 0));
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
    @(negedge clk);
    chk("zero_err", 32'(err), 0);
    @(posedge clk); #1;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
